// File: rtl/ssd_pkg.sv
// Shared types and segment decode for the seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g}; all codes are active-low.
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b1111110;

    typedef enum logic {IDLE, CONV} conv_state_t;

    function automatic seg_t hex_to_seg(input logic [3:0] h);
        seg_t s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Load-side bus of the scan driver: value/mode/mask strobe in, status out.
interface ssd_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    localparam int VAL_W = 4 * N_DIGITS;

    logic [VAL_W-1:0]    value;
    logic                load;
    logic                dec_mode;
    logic [N_DIGITS-1:0] dp_mask;
    logic                busy;
    logic                ovf;

    modport master (output value, load, dec_mode, dp_mask, input busy, ovf);
    modport slave  (input value, load, dec_mode, dp_mask, output busy, ovf);
endinterface

// File: rtl/ssd_bin2bcd.sv
// Sequential double-dabble converter, one input bit per cycle.
// busy is high for exactly VAL_W cycles after start; done marks the last one,
// and bcd carries the finished result during that cycle so the caller can
// capture it on the same edge the FSM returns to IDLE.
module ssd_bin2bcd
    import ssd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    localparam int VAL_W = 4 * N_DIGITS,
    localparam int BCD_W = 4 * (N_DIGITS + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    localparam int CNT_W = $clog2(VAL_W + 1);

    conv_state_t      state_q, state_d;
    logic [VAL_W-1:0] sh_q;
    logic [BCD_W-1:0] bcd_q, adj, bcd_step;
    logic [CNT_W-1:0] cnt_q;
    logic             last;

    assign last = (cnt_q == CNT_W'(VAL_W - 1));
    assign busy = (state_q == CONV);
    assign done = busy & last;
    assign bcd  = bcd_step;

    // One double-dabble step: add 3 to every digit >= 5, then shift in next bit
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < N_DIGITS + 2; i++)
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        bcd_step = {adj[BCD_W-2:0], sh_q[VAL_W-1]};
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                sh_q  <= bin;
                bcd_q <= '0;
                cnt_q <= '0;
            end else if (state_q == CONV) begin
                sh_q  <= sh_q << 1;
                bcd_q <= bcd_step;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// N-digit seven-segment scan driver with hex or decimal display.
// Optional build macro SSD_LZB_EN enables leading-zero blanking.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV_BITS = 18
) (
    input  logic                clk,
    input  logic                reset,
    ssd_scan_driver_if.slave    bus,
    output logic [N_DIGITS-1:0] an,
    output seg_t                seg,
    output logic                dp
);
    localparam int VAL_W = 4 * N_DIGITS;
    localparam int BCD_W = 4 * (N_DIGITS + 2);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [N_DIGITS-1:0] ONE = 1;

    logic [SCAN_DIV_BITS-1:0]  presc_q;
    logic [IDX_W-1:0]          idx_q;
    logic [N_DIGITS-1:0][3:0]  dig_q;
    logic [N_DIGITS-1:0]       dp_q, dp_pend_q, blank_v;
    logic                      ovf_q;
    logic                      conv_busy, conv_done, start, hex_ld;
    logic [BCD_W-1:0]          bcd;
    logic [3:0]                cur_dig;
    seg_t                      cur_seg;
    logic                      cur_blank;

    assign start    = bus.load & ~conv_busy &  bus.dec_mode;
    assign hex_ld   = bus.load & ~conv_busy & ~bus.dec_mode;
    assign bus.busy = conv_busy;
    assign bus.ovf  = ovf_q;

    ssd_bin2bcd #(.N_DIGITS(N_DIGITS)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bus.value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Prescaler and digit index; idx advances once per prescaler wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q)
                idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Digit/dp registers: hex loads apply at once, decimal results on done
    always_ff @(posedge clk) begin
        if (reset) begin
            dig_q     <= '0;
            dp_q      <= '0;
            dp_pend_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (start) dp_pend_q <= bus.dp_mask;
            if (conv_done) begin
                dig_q <= bcd[VAL_W-1:0];
                dp_q  <= dp_pend_q;
                ovf_q <= |bcd[BCD_W-1:VAL_W];
            end else if (hex_ld) begin
                dig_q <= bus.value;
                dp_q  <= bus.dp_mask;
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef SSD_LZB_EN
    // Blank zero digits above the highest non-zero one (digit 0 always shown)
    always_comb begin
        logic run;
        run     = 1'b1;
        blank_v = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run        = run & (dig_q[k] == 4'd0);
            blank_v[k] = (k != 0) && run && !dp_q[k] && !ovf_q;
        end
    end
`else
    assign blank_v = '0;
`endif

    // Select the currently scanned digit
    always_comb begin
        cur_dig   = dig_q[idx_q];
        cur_seg   = ovf_q ? SEG_DASH : hex_to_seg(cur_dig);
        cur_blank = blank_v[idx_q];
    end

    // Registered board outputs
    always_ff @(posedge clk) begin
        if (reset || cur_blank) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(ONE << idx_q);
            seg <= cur_seg;
            dp  <= ~dp_q[idx_q];
        end
    end

endmodule
